// File: rtl/disp_pkg.sv
// ---------------------------------------------------------------------------
// disp_pkg
// Shared definitions for the debug display source scheduler:
//   - state_t        : scheduler FSM states (SETTLE, SHOW, ADVANCE)
//   - SETTLE_CYCLES  : cycles spent waiting for sel_out + registered mux
//   - SRC_*          : source index of each debug value on the mux
//   - HEX7_N         : active-low {g,f,e,d,c,b,a} patterns for hex 0..F
// ---------------------------------------------------------------------------
package disp_pkg;

    typedef enum logic [1:0] {
        SETTLE  = 2'd0,
        SHOW    = 2'd1,
        ADVANCE = 2'd2
    } state_t;

    // One cycle for the sel_out register, one for the registered source mux.
    localparam int unsigned SETTLE_CYCLES = 2;

    localparam logic [2:0] SRC_SYSCALL = 3'd0;
    localparam logic [2:0] SRC_PC      = 3'd1;
    localparam logic [2:0] SRC_TIME    = 3'd2;
    localparam logic [2:0] SRC_J       = 3'd3;
    localparam logic [2:0] SRC_B_OK    = 3'd4;
    localparam logic [2:0] SRC_B       = 3'd5;
    localparam logic [2:0] SRC_MDATA   = 3'd6;
    localparam logic [2:0] SRC_LOADUSE = 3'd7;

    // Index = nibble value; a segment is lit when its bit is 0.
    localparam logic [6:0] HEX7_N [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
        7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
    };

endpackage

// File: rtl/disp_src_scheduler_if.sv
// ---------------------------------------------------------------------------
// disp_src_scheduler_if
// Bundles the scheduler's control inputs, mux data and display pins.
//   auto_en    : 1 = auto-rotate sources, 0 = follow manual_sel
//   manual_sel : source select from the board switches
//   freeze     : hold source, display contents and dwell count
//   data_in    : value from the registered source mux
//   sel_out    : source select driven to the mux
//   an_n       : digit anodes, active-low, bit i = digit i (0 rightmost)
//   seg_n      : segments {dp,g,f,e,d,c,b,a}, active-low
// Modports: master (board/bench side), slave (scheduler side).
// ---------------------------------------------------------------------------
interface disp_src_scheduler_if;

    logic        auto_en;
    logic [2:0]  manual_sel;
    logic        freeze;
    logic [31:0] data_in;
    logic [2:0]  sel_out;
    logic [7:0]  an_n;
    logic [7:0]  seg_n;

    modport master (
        output auto_en, manual_sel, freeze, data_in,
        input  sel_out, an_n, seg_n
    );

    modport slave (
        input  auto_en, manual_sel, freeze, data_in,
        output sel_out, an_n, seg_n
    );

endinterface

// File: rtl/hex7seg.sv
// ---------------------------------------------------------------------------
// hex7seg
// Combinational hex-to-seven-segment decoder.
//   nibble : 4-bit value to display
//   seg_n  : active-low {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module hex7seg
    import disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    assign seg_n = HEX7_N[nibble];

endmodule

// File: rtl/disp_src_scheduler.sv
// ---------------------------------------------------------------------------
// disp_src_scheduler
// Picks which of the 8 debug sources feeds the display (auto rotation or
// switches) and scans the 32-bit value onto an 8-digit multiplexed
// seven-segment display.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : disp_src_scheduler_if.slave (controls, mux data, display pins)
// Parameters:
//   SCAN_DIV    : clock cycles each digit is lit (>= 2)
//   DWELL_SCANS : full 8-digit scan rounds per source in auto mode (>= 1)
// Build option:
//   DISP_SRC_DP_EN : when defined, the decimal point is lit on the digit whose
//                    index equals sel_out, identifying the current source.
// ---------------------------------------------------------------------------
module disp_src_scheduler
    import disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV    = 50000,
    parameter int unsigned DWELL_SCANS = 256
) (
    input logic                 clk,
    input logic                 rst_n,
    disp_src_scheduler_if.slave bus
);

    localparam int unsigned SCAN_W   = $clog2(SCAN_DIV);
    localparam int unsigned DWELL_W  = (DWELL_SCANS > 1) ? $clog2(DWELL_SCANS) : 1;
    localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [SCAN_W-1:0]   SCAN_LAST   = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DWELL_W-1:0]  DWELL_LAST  = DWELL_W'(DWELL_SCANS - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Scan timing: free-running, never paused by freeze or settling.
    // ------------------------------------------------------------------
    logic [SCAN_W-1:0] scan_cnt;
    logic [2:0]        digit;
    logic              scan_term;
    logic              round_end;

    assign scan_term = (scan_cnt == SCAN_LAST);
    assign round_end = scan_term && (digit == 3'd7);

    // NOTE: clocked state is always assigned with <= so every flop samples
    // the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            digit    <= 3'd0;
        end else if (scan_term) begin
            scan_cnt <= '0;
            digit    <= digit + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Source scheduler FSM
    // ------------------------------------------------------------------
    state_t              state, state_next;
    logic [SETTLE_W-1:0] settle_cnt, settle_next;
    logic [DWELL_W-1:0]  dwell_cnt, dwell_next;
    logic [2:0]          sel_reg, sel_next;
    logic [31:0]         disp_reg, disp_next;
    logic                manual_change;

    // Freeze outranks a switch change, which outranks auto rotation.
    assign manual_change = !bus.auto_en && !bus.freeze && (bus.manual_sel != sel_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SETTLE;
            settle_cnt <= '0;
            dwell_cnt  <= '0;
            sel_reg    <= SRC_SYSCALL;
            disp_reg   <= '0;
        end else begin
            state      <= state_next;
            settle_cnt <= settle_next;
            dwell_cnt  <= dwell_next;
            sel_reg    <= sel_next;
            disp_reg   <= disp_next;
        end
    end

    // NOTE: every output of this block gets a hold value first, so no path
    // through the case statement can leave a signal unassigned (no latches).
    always_comb begin
        state_next  = state;
        settle_next = settle_cnt;
        dwell_next  = dwell_cnt;
        sel_next    = sel_reg;
        disp_next   = disp_reg;

        if (manual_change) begin
            // Restarts settling even when already in SETTLE.
            sel_next    = bus.manual_sel;
            dwell_next  = '0;
            state_next  = SETTLE;
            settle_next = '0;
        end else begin
            // Dwell is meaningless in manual mode; keeping it at zero means
            // a later switch to auto starts a fresh dwell without SETTLE.
            if (!bus.auto_en && !bus.freeze) begin
                dwell_next = '0;
            end

            unique case (state)
                SETTLE: begin
                    // Settling only waits out pipeline latency, so it keeps
                    // running while frozen.
                    if (settle_cnt == SETTLE_LAST) begin
                        state_next  = SHOW;
                        settle_next = '0;
                    end else begin
                        settle_next = settle_cnt + SETTLE_W'(1);
                    end
                end
                SHOW: begin
                    if (!bus.freeze) begin
                        disp_next = bus.data_in;
                        if (bus.auto_en && round_end) begin
                            if (dwell_cnt == DWELL_LAST) begin
                                state_next = ADVANCE;
                                dwell_next = '0;
                            end else begin
                                dwell_next = dwell_cnt + DWELL_W'(1);
                            end
                        end
                    end
                end
                ADVANCE: begin
                    // A frozen advance waits here until release.
                    if (!bus.freeze) begin
                        sel_next    = sel_reg + 3'd1;
                        state_next  = SETTLE;
                        settle_next = '0;
                    end
                end
                default: begin
                    state_next  = SETTLE;
                    settle_next = '0;
                end
            endcase
        end
    end

    assign bus.sel_out = sel_reg;

    // ------------------------------------------------------------------
    // Display drive: registered anode/segment outputs for the current digit
    // ------------------------------------------------------------------
    logic [3:0] nibble;
    logic [6:0] hex_seg;
    logic       dp_n;
    logic [7:0] an_reg;
    logic [7:0] seg_reg;

    assign nibble = disp_reg[{digit, 2'b00} +: 4];

    hex7seg u_hex7seg (
        .nibble (nibble),
        .seg_n  (hex_seg)
    );

`ifdef DISP_SRC_DP_EN
    assign dp_n = (digit != sel_reg);
`else
    assign dp_n = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_reg  <= 8'hFF;
            seg_reg <= 8'hFF;
        end else begin
            an_reg  <= ~(8'h01 << digit);
            seg_reg <= {dp_n, hex_seg};
        end
    end

    assign bus.an_n  = an_reg;
    assign bus.seg_n = seg_reg;

endmodule
